cgra0_rd_arbiter: RTL and testbench
===================================

# cgra0_rd_arbiter

Round-robin arbiter that shares the single 512-bit host read channel of the CGRA accelerator among NUM_REQ clients: the configuration controller (client 0) and the input-queue fillers (clients 1..NUM_REQ-1). It holds one outstanding read at a time and routes the returned cache line only to the granted client. A watchdog recovers from lost responses. It sits between the clients and the accelerator's memory read port, inside the acc0 top.

## Interface

Parameters:

- NUM_REQ, 9, number of clients (index 0 = configuration controller).
- DATA_W, 512, cache-line width.
- TIMEOUT, 1024, max cycles in WAIT_DATA before abort (≥2).

Ports. Reset: rst, synchronous, active-high. Clock: clk.

- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- client_req  in  NUM_REQ  level request per client; held high until that client's client_valid pulse.
- client_valid  out  NUM_REQ  one-cycle pulse; data for that client is on client_data.
- client_err  out  NUM_REQ  one-cycle pulse coincident with client_valid when the read timed out.
- client_data  out  DATA_W  registered line, shared by all clients.
- mem_available_read  in  1  memory port can accept a request.
- mem_req_rd_data  out  1  one-cycle request pulse.
- mem_rd_sel  out  $clog2(NUM_REQ)  index of the granted client; stable from the request until release.
- mem_rd_data  in  DATA_W  returned line.
- mem_rd_data_valid  in  1  returned line valid.
- busy  out  1  high in every state except ARB.
- timeout_flag  out  1  sticky; set on the first timeout, cleared only by rst.

## Operation

- FSM states: ARB, WAIT_DATA, DONE.
- ARB:
  - When mem_available_read && |client_req, pick the winner by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - On a win: grant <= winner, mem_rd_sel <= winner, mem_req_rd_data <= 1 for one cycle, wait_cnt <= 0, go to WAIT_DATA.
  - With no request or no mem_available_read, stay in ARB with no pulse.
- WAIT_DATA:
  - If mem_rd_data_valid: client_data <= mem_rd_data, client_valid[grant] <= 1, go to DONE.
  - Else if wait_cnt == TIMEOUT-1: client_data <= 0, client_valid[grant] <= 1, client_err[grant] <= 1, timeout_flag <= 1, go to DONE.
  - Else wait_cnt increments.
  - If valid arrives in the same cycle wait_cnt reaches TIMEOUT-1, valid wins and there is no error.
- DONE: one cycle. last_grant <= grant, then go to ARB. This cycle lets the served client drop its request, so it is not re-granted.
- mem_rd_data_valid outside WAIT_DATA is ignored: no output change, no state change.
- A client that drops client_req while granted does not cancel the read; the data is still delivered to it.
- wait_cnt is $clog2(TIMEOUT+1) bits wide and never wraps.

## Timing

- Reset values: all outputs 0, client_data 0, state ARB, last_grant = NUM_REQ-1 (client 0 wins the first arbitration), wait_cnt 0.
- A reset in any state aborts the outstanding read. A late mem_rd_data_valid after reset is ignored because the FSM is in ARB.
- Request latency: client_req high at edge t, with the FSM in ARB and mem_available_read high → mem_req_rd_data high in cycle t+1.
- Return latency: mem_rd_data_valid at edge u → client_valid and client_data in cycle u+1. DONE occupies u+1; ARB samples again at u+2.
- Back-to-back minimum: 3 cycles per grant plus memory latency.
- A client must deassert client_req no later than the edge following its client_valid pulse.

## Structure

- Shared package cgra0_pkg holds the FSM state encoding (ARB=0, WAIT_DATA=1, DONE=2) and the default DATA_W.
- Sub-module cgra0_rr_pick: combinational round-robin pick, with inputs req vector and last_grant, and outputs winner and any.
- Remaining logic (FSM, counters, data register) is in the top.

## Test plan

- Single client: client_req[0]=1, mem_available_read=1, data returned 5 cycles after the request with value 0xA5…A5 → one mem_req pulse with mem_rd_sel=0; client_valid[0] 1 cycle later with client_data=0xA5…A5; busy low afterwards.
- Fairness: clients 0, 3 and 8 requesting continuously, with requests re-raised after each service → grant order 0,3,8,0,3,8; no client is served twice in a row while others are waiting.
- Wrap: last_grant=8, requests on 2 and 5 → 2 is granted first.
- Backpressure: mem_available_read=0 for 10 cycles with requests pending → no mem_req pulse and busy stays 0; a pulse appears 1 cycle after mem_available_read rises.
- Timeout: TIMEOUT=16, no response → client_valid and client_err for the granted client exactly 16 cycles after WAIT_DATA entry, client_data=0, timeout_flag stays 1. A spurious mem_rd_data_valid afterwards is ignored.
- Reset mid-read: rst in WAIT_DATA, then a late mem_rd_data_valid → no client_valid, state ARB; the next arbitration grants client 0 first.

Source files
------------

// File: rtl/cgra0_pkg.sv
// Shared definitions for the CGRA host-read arbitration slice.
package cgra0_pkg;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    WAIT_DATA = 2'd1,
    DONE      = 2'd2
  } rd_state_t;

  localparam int unsigned DEF_DATA_W = 512;

endpackage

// File: rtl/cgra0_rr_pick.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module cgra0_rr_pick #(
  parameter int unsigned NUM_REQ = 9,
  parameter int unsigned SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last_grant,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  logic [SEL_W-1:0] w_idx;

  // Offsets 1..NUM_REQ so last_grant itself is considered last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_idx = SEL_W'(({{(32-SEL_W){1'b0}}, last_grant} + i) % NUM_REQ);
      if (!any && req[w_idx]) begin
        winner = w_idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cgra0_rd_arbiter.sv
// Round-robin arbiter sharing the single host read channel among NUM_REQ clients,
// one outstanding read at a time, with a watchdog for lost responses.
module cgra0_rd_arbiter
  import cgra0_pkg::*;
#(
  parameter int unsigned NUM_REQ = 9,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         client_req,
  output logic [NUM_REQ-1:0]         client_valid,
  output logic [NUM_REQ-1:0]         client_err,
  output logic [DATA_W-1:0]          client_data,
  input  logic                       mem_available_read,
  output logic                       mem_req_rd_data,
  output logic [$clog2(NUM_REQ)-1:0] mem_rd_sel,
  input  logic [DATA_W-1:0]          mem_rd_data,
  input  logic                       mem_rd_data_valid,
  output logic                       busy,
  output logic                       timeout_flag
);

  localparam int unsigned SEL_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  rd_state_t          r_state;
  logic [SEL_W-1:0]   r_grant;
  logic [SEL_W-1:0]   r_last_grant;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [DATA_W-1:0]  r_client_data;
  logic [NUM_REQ-1:0] r_client_valid;
  logic [NUM_REQ-1:0] r_client_err;
  logic               r_mem_req;
  logic               r_timeout_flag;

  logic [SEL_W-1:0]   w_winner;
  logic               w_any;
  logic [NUM_REQ-1:0] w_grant_oh;

  cgra0_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req        (client_req),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .any        (w_any)
  );

  assign w_grant_oh = NUM_REQ'(1) << r_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ARB;
      r_grant        <= '0;
      r_last_grant   <= SEL_W'(NUM_REQ - 1);
      r_wait_cnt     <= '0;
      r_client_data  <= '0;
      r_client_valid <= '0;
      r_client_err   <= '0;
      r_mem_req      <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_mem_req      <= 1'b0;
      r_client_valid <= '0;
      r_client_err   <= '0;
      unique case (r_state)
        ARB: begin
          if (mem_available_read && w_any) begin
            r_grant    <= w_winner;
            r_mem_req  <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          // Valid is tested first so a response on the last watchdog cycle still counts.
          if (mem_rd_data_valid) begin
            r_client_data  <= mem_rd_data;
            r_client_valid <= w_grant_oh;
            r_state        <= DONE;
          end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_client_data  <= '0;
            r_client_valid <= w_grant_oh;
            r_client_err   <= w_grant_oh;
            r_timeout_flag <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_last_grant <= r_grant;
          r_state      <= ARB;
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign client_valid    = r_client_valid;
  assign client_err      = r_client_err;
  assign client_data     = r_client_data;
  assign mem_req_rd_data = r_mem_req;
  assign mem_rd_sel      = r_grant;
  assign busy            = (r_state != ARB);
  assign timeout_flag    = r_timeout_flag;

endmodule

// File: tb/tb_cgra0_rd_arbiter.sv
// Directed bench for cgra0_rd_arbiter (NUM_REQ=9, TIMEOUT=16).
module tb_cgra0_rd_arbiter;

  localparam int unsigned NUM_REQ = 9;
  localparam int unsigned DATA_W  = 512;
  localparam int unsigned TIMEOUT = 16;

  logic               clk;
  logic               rst;
  logic [NUM_REQ-1:0] client_req;
  logic [NUM_REQ-1:0] client_valid;
  logic [NUM_REQ-1:0] client_err;
  logic [DATA_W-1:0]  client_data;
  logic               mem_available_read;
  logic               mem_req_rd_data;
  logic [3:0]         mem_rd_sel;
  logic [DATA_W-1:0]  mem_rd_data;
  logic               mem_rd_data_valid;
  logic               busy;
  logic               timeout_flag;

  int tests = 0;
  int fails = 0;

  cgra0_rd_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .client_req         (client_req),
    .client_valid       (client_valid),
    .client_err         (client_err),
    .client_data        (client_data),
    .mem_available_read (mem_available_read),
    .mem_req_rd_data    (mem_req_rd_data),
    .mem_rd_sel         (mem_rd_sel),
    .mem_rd_data        (mem_rd_data),
    .mem_rd_data_valid  (mem_rd_data_valid),
    .busy               (busy),
    .timeout_flag       (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the request pulse, then checks latency, select and busy.
  task automatic wait_req(input string tag, input int exp_sel);
    int n;
    n = 0;
    while (mem_req_rd_data !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, DATA_W'(n), DATA_W'(1));
    chk({tag, "_sel"}, DATA_W'(mem_rd_sel), DATA_W'(exp_sel));
    chk({tag, "_busy"}, DATA_W'(busy), DATA_W'(1));
  endtask

  // Returns a line after lat cycles, checks delivery, then releases the client.
  task automatic ret(input string tag, input int c, input int lat, input logic [DATA_W-1:0] d);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[c] = 1'b1;
    tick();
    chk({tag, "_pulse1"}, DATA_W'(mem_req_rd_data), DATA_W'(0));
    repeat (lat - 1) tick();
    mem_rd_data       = d;
    mem_rd_data_valid = 1'b1;
    tick();
    mem_rd_data_valid = 1'b0;
    mem_rd_data       = '0;
    chk({tag, "_valid"}, DATA_W'(client_valid), DATA_W'(oh));
    chk({tag, "_err"}, DATA_W'(client_err), DATA_W'(0));
    chk({tag, "_data"}, client_data, d);
    client_req[c] = 1'b0;
    tick();
    chk({tag, "_vdrop"}, DATA_W'(client_valid), DATA_W'(0));
    chk({tag, "_idle"}, DATA_W'(busy), DATA_W'(0));
  endtask

  initial begin
    logic [DATA_W-1:0] a5;
    logic [DATA_W-1:0] ff;
    int order[6];
    a5 = {64{8'hA5}};
    ff = '1;
    order = '{0, 3, 8, 0, 3, 8};

    rst = 1'b1;
    client_req = '0;
    mem_available_read = 1'b0;
    mem_rd_data = '0;
    mem_rd_data_valid = 1'b0;
    tick();
    tick();
    chk("rst_valid", DATA_W'(client_valid), DATA_W'(0));
    chk("rst_err", DATA_W'(client_err), DATA_W'(0));
    chk("rst_data", client_data, '0);
    chk("rst_req", DATA_W'(mem_req_rd_data), DATA_W'(0));
    chk("rst_sel", DATA_W'(mem_rd_sel), DATA_W'(0));
    chk("rst_busy", DATA_W'(busy), DATA_W'(0));
    chk("rst_tflag", DATA_W'(timeout_flag), DATA_W'(0));
    rst = 1'b0;

    // Single client
    mem_available_read = 1'b1;
    client_req = 9'b0_0000_0001;
    wait_req("single", 0);
    ret("single", 0, 5, a5);

    // Fairness from a fresh reset: 0,3,8 repeating
    rst = 1'b1;
    tick();
    rst = 1'b0;
    client_req = 9'b1_0000_1001;
    for (int k = 0; k < 6; k++) begin
      wait_req($sformatf("fair%0d", k), order[k]);
      ret($sformatf("fair%0d", k), order[k], 2, DATA_W'(k + 100));
      if (k < 5) client_req[order[k]] = 1'b1;
    end

    // Wrap: last grant was 8, requests on 2 and 5
    client_req = 9'b0_0010_0100;
    wait_req("wrap_a", 2);
    ret("wrap_a", 2, 3, DATA_W'(32'h2222));
    wait_req("wrap_b", 5);
    ret("wrap_b", 5, 1, DATA_W'(32'h5555));

    // Backpressure
    mem_available_read = 1'b0;
    client_req = 9'b0_0000_0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("bp_req%0d", k), DATA_W'(mem_req_rd_data), DATA_W'(0));
      chk($sformatf("bp_busy%0d", k), DATA_W'(busy), DATA_W'(0));
    end
    mem_available_read = 1'b1;
    wait_req("bp", 1);
    ret("bp", 1, 2, a5);

    // Timeout on client 4
    client_req = 9'b0_0001_0000;
    wait_req("to", 4);
    repeat (15) tick();
    chk("to_early", DATA_W'(client_valid), DATA_W'(0));
    chk("to_tflag0", DATA_W'(timeout_flag), DATA_W'(0));
    tick();
    chk("to_valid", DATA_W'(client_valid), DATA_W'(9'b0_0001_0000));
    chk("to_err", DATA_W'(client_err), DATA_W'(9'b0_0001_0000));
    chk("to_data", client_data, '0);
    chk("to_tflag", DATA_W'(timeout_flag), DATA_W'(1));
    client_req = '0;
    tick();
    chk("to_err_drop", DATA_W'(client_err), DATA_W'(0));
    mem_rd_data = ff;
    mem_rd_data_valid = 1'b1;
    tick();
    mem_rd_data_valid = 1'b0;
    mem_rd_data = '0;
    chk("spur_valid", DATA_W'(client_valid), DATA_W'(0));
    chk("spur_data", client_data, '0);
    chk("spur_busy", DATA_W'(busy), DATA_W'(0));
    chk("spur_tflag", DATA_W'(timeout_flag), DATA_W'(1));

    // Response on the last watchdog cycle wins over the timeout
    client_req = 9'b0_0100_0000;
    wait_req("edge", 6);
    repeat (15) tick();
    mem_rd_data = a5;
    mem_rd_data_valid = 1'b1;
    tick();
    mem_rd_data_valid = 1'b0;
    mem_rd_data = '0;
    chk("edge_valid", DATA_W'(client_valid), DATA_W'(9'b0_0100_0000));
    chk("edge_err", DATA_W'(client_err), DATA_W'(0));
    chk("edge_data", client_data, a5);
    client_req = '0;
    tick();

    // Reset mid-read, then a late response
    client_req = 9'b0_1000_0000;
    wait_req("mid", 7);
    tick();
    tick();
    rst = 1'b1;
    client_req = '0;
    tick();
    rst = 1'b0;
    chk("mid_busy", DATA_W'(busy), DATA_W'(0));
    chk("mid_tflag", DATA_W'(timeout_flag), DATA_W'(0));
    mem_rd_data = ff;
    mem_rd_data_valid = 1'b1;
    tick();
    mem_rd_data_valid = 1'b0;
    mem_rd_data = '0;
    chk("late_valid", DATA_W'(client_valid), DATA_W'(0));
    chk("late_data", client_data, '0);
    chk("late_busy", DATA_W'(busy), DATA_W'(0));
    client_req = 9'b0_1000_0001;
    wait_req("post_a", 0);
    ret("post_a", 0, 2, a5);
    wait_req("post_b", 7);
    ret("post_b", 7, 2, ff);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
